// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_pkg: opcodes, format codes and decoded-entry layout shared |
// | by the operand-fetch stage and its decoder.  Rev 1.0             |
// +------------------------------------------------------------------+
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SYS = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  // XLEN-wide fields (pc, imm) live in separate arrays so this layout stays XLEN-agnostic.
  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_en;
    logic        is_imm;
    fmt_e        fmt;
    logic        illegal;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/of_imm_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | of_imm_gen: combinational decode of one instruction into imm,    |
// | register addresses/enables, format, is_imm and illegal. Rev 1.0  |
// +------------------------------------------------------------------+
module of_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            rs1_en,
  output logic            rs2_en,
  output logic            rd_en,
  output logic            is_imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  fmt_e fmt_w;
  logic rs1_use, rs2_use, rd_use;

  // Every supported opcode ends in 2'b11, so a full 7-bit match also rejects compressed encodings.
  always_comb begin
    fmt_w   = FMT_ILL;
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    rd_use  = 1'b0;
    is_imm  = 1'b0;
    case (instr[6:0])
      OP_R:                      begin fmt_w = FMT_R;   rs1_use = 1'b1; rs2_use = 1'b1; rd_use = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR:  begin fmt_w = FMT_I;   rs1_use = 1'b1; rd_use = 1'b1; is_imm = 1'b1; end
      OP_STORE:                  begin fmt_w = FMT_S;   rs1_use = 1'b1; rs2_use = 1'b1; end
      OP_BRANCH:                 begin fmt_w = FMT_B;   rs1_use = 1'b1; rs2_use = 1'b1; end
      OP_LUI, OP_AUIPC:          begin fmt_w = FMT_U;   rd_use = 1'b1; end
      OP_JAL:                    begin fmt_w = FMT_J;   rd_use = 1'b1; end
      OP_SYSTEM:                 begin fmt_w = FMT_SYS; rs1_use = 1'b1; rd_use = 1'b1; is_imm = 1'b1; end
      default:                   ;
    endcase
  end

  always_comb begin
    imm = {XLEN{instr[31]}};
    case (fmt_w)
      FMT_I, FMT_SYS: imm[11:0] = instr[31:20];
      FMT_S:          imm[11:0] = {instr[31:25], instr[11:7]};
      FMT_B:          imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:          imm[31:0] = {instr[31:12], 12'b0};
      FMT_J:          imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:        imm = '0;
    endcase
  end

  assign rs1_en  = rs1_use;
  assign rs2_en  = rs2_use;
  assign rd_en   = rd_use && (instr[11:7] != 5'd0);
  assign rs1     = rs1_en ? instr[19:15] : 5'd0;
  assign rs2     = rs2_en ? instr[24:20] : 5'd0;
  assign rd      = rd_en  ? instr[11:7]  : 5'd0;
  assign fmt     = fmt_w;
  assign illegal = (fmt_w == FMT_ILL);

endmodule
`default_nettype wire

// File: rtl/of_stage_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | of_stage_pipe: operand-fetch/decode stage with a DEPTH-entry     |
// | in-order queue, valid/ready on both sides and flush. Rev 1.0     |
// +------------------------------------------------------------------+
module of_stage_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk2,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic                       out_rs1_en,
  output logic                       out_rs2_en,
  output logic                       out_rd_en,
  output logic [XLEN-1:0]            out_imm,
  output logic                       out_is_imm,
  output logic [2:0]                 out_fmt,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  dec_t            dec_ent;

  of_imm_gen #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .rs1     (dec_ent.rs1),
    .rs2     (dec_ent.rs2),
    .rd      (dec_ent.rd),
    .rs1_en  (dec_ent.rs1_en),
    .rs2_en  (dec_ent.rs2_en),
    .rd_en   (dec_ent.rd_en),
    .is_imm  (dec_ent.is_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ent.illegal)
  );
  assign dec_ent.instr = in_instr;
  assign dec_ent.fmt   = fmt_e'(dec_fmt);

  dec_t            ent_q [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [XLEN-1:0] imm_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (occupancy < OW'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk2) begin
    if (!rst || flush) begin
      occupancy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
    end
  end

  // Storage has no reset; the empty-queue output mux hides stale slots.
  always_ff @(posedge clk2) begin
    if (rst && !flush && push) begin
      ent_q[wr_ptr] <= dec_ent;
      pc_q[wr_ptr]  <= in_pc;
      imm_q[wr_ptr] <= dec_imm;
    end
  end

  dec_t head;
  assign head = ent_q[rd_ptr];

  assign out_pc      = out_valid ? pc_q[rd_ptr]  : '0;
  assign out_imm     = out_valid ? imm_q[rd_ptr] : '0;
  assign out_instr   = out_valid ? head.instr    : NOP;
  assign out_rs1     = out_valid ? head.rs1      : 5'd0;
  assign out_rs2     = out_valid ? head.rs2      : 5'd0;
  assign out_rd      = out_valid ? head.rd       : 5'd0;
  assign out_rs1_en  = out_valid && head.rs1_en;
  assign out_rs2_en  = out_valid && head.rs2_en;
  assign out_rd_en   = out_valid && head.rd_en;
  assign out_is_imm  = out_valid && head.is_imm;
  assign out_illegal = out_valid && head.illegal;
  assign out_fmt     = out_valid ? head.fmt      : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_of_stage_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_of_stage_pipe: directed self-checking bench, XLEN=32 and      |
// | XLEN=64 instances with DEPTH=2. Rev 1.0                          |
// +------------------------------------------------------------------+
module tb_of_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  logic a_in_valid, a_out_ready;
  logic [31:0] a_in_pc, a_in_instr;
  logic a_in_ready, a_out_valid;
  logic [31:0] a_out_pc, a_out_instr, a_out_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic a_rs1_en, a_rs2_en, a_rd_en, a_is_imm, a_illegal;
  logic [2:0] a_fmt;
  logic [1:0] a_occ;

  logic b_flush, b_in_valid, b_out_ready;
  logic [63:0] b_in_pc;
  logic [31:0] b_in_instr;
  logic b_in_ready, b_out_valid;
  logic [63:0] b_out_pc, b_out_imm;
  logic [31:0] b_out_instr;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic b_rs1_en, b_rs2_en, b_rd_en, b_is_imm, b_illegal;
  logic [2:0] b_fmt;
  logic [1:0] b_occ;

  int checks = 0;
  int errors = 0;

  of_stage_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk2(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_instr(a_in_instr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc), .out_instr(a_out_instr),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
    .out_rs1_en(a_rs1_en), .out_rs2_en(a_rs2_en), .out_rd_en(a_rd_en),
    .out_imm(a_out_imm), .out_is_imm(a_is_imm), .out_fmt(a_fmt), .out_illegal(a_illegal),
    .occupancy(a_occ)
  );

  of_stage_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk2(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_instr(b_in_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc), .out_instr(b_out_instr),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
    .out_rs1_en(b_rs1_en), .out_rs2_en(b_rs2_en), .out_rd_en(b_rd_en),
    .out_imm(b_out_imm), .out_is_imm(b_is_imm), .out_fmt(b_fmt), .out_illegal(b_illegal),
    .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs changed after this return apply at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_pc = '0; a_in_instr = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_pc = '0; b_in_instr = '0;
    #1;
    step(); step();
    rst = 1'b1;

    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready",  a_in_ready, 1);
    check("rst_occ",       a_occ, 0);
    check("rst_out_instr", a_out_instr, 64'h13);
    check("rst_out_imm",   a_out_imm, 0);
    check("rst_out_pc",    a_out_pc, 0);

    // I-type addi x1, x0, -1
    a_in_valid = 1'b1; a_in_pc = 32'h100; a_in_instr = 32'hFFF00093;
    step();
    a_in_valid = 1'b0;
    check("i_valid",  a_out_valid, 1);
    check("i_pc",     a_out_pc, 64'h100);
    check("i_imm",    a_out_imm, 64'hFFFFFFFF);
    check("i_is_imm", a_is_imm, 1);
    check("i_rs1_en", a_rs1_en, 1);
    check("i_rs1",    a_rs1, 0);
    check("i_rd",     a_rd, 1);
    check("i_rd_en",  a_rd_en, 1);
    check("i_rs2_en", a_rs2_en, 0);
    check("i_fmt",    a_fmt, 1);
    check("i_occ",    a_occ, 1);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    check("i_pop_valid", a_out_valid, 0);

    // B-type beq x0, x0, -4
    a_in_valid = 1'b1; a_in_pc = 32'h104; a_in_instr = 32'hFE000EE3;
    step();
    a_in_valid = 1'b0;
    check("b_imm",    a_out_imm, 64'hFFFFFFFC);
    check("b_fmt",    a_fmt, 3);
    check("b_rs2_en", a_rs2_en, 1);
    check("b_rd_en",  a_rd_en, 0);
    check("b_is_imm", a_is_imm, 0);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;

    // Backpressure: A = sw x2,8(x1), B = auipc x5,0x12345, C = addi x1,x0,-1
    a_in_valid = 1'b1; a_in_pc = 32'h200; a_in_instr = 32'h0020A423;
    step();
    check("bp_ready_after_a", a_in_ready, 1);
    a_in_pc = 32'h204; a_in_instr = 32'h12345297;
    step();
    check("bp_ready_full", a_in_ready, 0);
    check("bp_occ_full",   a_occ, 2);
    a_in_pc = 32'h208; a_in_instr = 32'hFFF00093;
    step();
    check("bp_occ_held",  a_occ, 2);
    check("bp_head_a_pc", a_out_pc, 64'h200);
    check("s_imm",        a_out_imm, 64'h8);
    check("s_fmt",        a_fmt, 2);
    check("s_rs1",        a_rs1, 1);
    check("s_rs2",        a_rs2, 2);
    check("s_rd",         a_rd, 0);
    a_out_ready = 1'b1;
    step();
    check("bp_head_b_pc", a_out_pc, 64'h204);
    check("u_imm",        a_out_imm, 64'h12345000);
    check("u_fmt",        a_fmt, 4);
    check("u_rd",         a_rd, 5);
    check("u_rs1_en",     a_rs1_en, 0);
    step();
    a_in_valid = 1'b0;
    check("bp_head_c_pc", a_out_pc, 64'h208);
    check("bp_head_c_in", a_out_instr, 64'hFFF00093);
    check("bp_occ_c",     a_occ, 1);
    step();
    check("bp_drained",   a_out_valid, 0);
    a_out_ready = 1'b0;

    // Flush with a push and pop offered in the same cycle
    a_in_valid = 1'b1; a_in_pc = 32'h300; a_in_instr = 32'h00000013;
    step();
    a_in_pc = 32'h304; a_in_instr = 32'h00100093;
    step();
    check("fl_occ_before", a_occ, 2);
    flush = 1'b1; a_out_ready = 1'b1; a_in_pc = 32'h308; a_in_instr = 32'h00200113;
    step();
    flush = 1'b0; a_in_valid = 1'b0;
    check("fl_occ",       a_occ, 0);
    check("fl_valid",     a_out_valid, 0);
    check("fl_instr_nop", a_out_instr, 64'h13);
    a_in_valid = 1'b1; a_in_pc = 32'h30C; a_in_instr = 32'h00300193;
    a_out_ready = 1'b0;
    step();
    a_in_valid = 1'b0;
    check("fl_next_pc",  a_out_pc, 64'h30C);
    check("fl_next_occ", a_occ, 1);

    // Reset mid-stream
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("mid_rst_occ",   a_occ, 0);
    check("mid_rst_valid", a_out_valid, 0);

    // XLEN=64: lui x5, 0x80000 then all-zero (illegal) pushed while popping
    b_in_valid = 1'b1; b_in_pc = 64'h1000; b_in_instr = 32'h800002B7;
    step();
    check("x64_lui_imm", b_out_imm, 64'hFFFFFFFF80000000);
    check("x64_lui_rd",  b_rd, 5);
    check("x64_lui_fmt", b_fmt, 4);
    b_out_ready = 1'b1; b_in_pc = 64'h1004; b_in_instr = 32'h00000000;
    step();
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    check("x64_ill_pc",   b_out_pc, 64'h1004);
    check("x64_illegal",  b_illegal, 1);
    check("x64_ill_fmt",  b_fmt, 7);
    check("x64_ill_ens",  {b_rs1_en, b_rs2_en, b_rd_en, b_is_imm}, 0);
    check("x64_ill_imm",  b_out_imm, 0);
    check("x64_ill_occ",  b_occ, 1);
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_pc = 64'h1008; b_in_instr = 32'hFFF00093;
    step();
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    check("x64_i_imm",    b_out_imm, 64'hFFFFFFFFFFFFFFFF);
    check("x64_i_pc",     b_out_pc, 64'h1008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
